// File: rtl/mem_arb.sv
// mem_arb: shares one memory port between the IFU and the LSU.
// One outstanding transaction at a time: IDLE (arbitrate) -> REQ
// (downstream handshake) -> RESP (wait for response) -> IDLE.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration
// on ties. When it is undefined, the LSU has fixed priority.
module mem_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ifu_req_valid_i,
  output logic                    ifu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  input  logic                    lsu_req_valid_i,
  output logic                    lsu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic                    lsu_wen_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask_i,
  output logic                    lsu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_wen_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  state_e                  state_q;
  logic                    owner_lsu_q;
  logic                    mem_req_valid_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;
`ifdef MEM_ARB_RR_EN
  // 1 = LSU was granted last, 0 = IFU was granted last.
  logic                    last_lsu_q;
`endif

  logic lsu_win;
  logic any_req;
  logic resp_fire;

  // Arbitration, request readies and response pass-through.
  always_comb begin
    any_req = ifu_req_valid_i | lsu_req_valid_i;
`ifdef MEM_ARB_RR_EN
    lsu_win = lsu_req_valid_i & (~ifu_req_valid_i | ~last_lsu_q);
`else
    lsu_win = lsu_req_valid_i;
`endif
    ifu_req_ready_o = (state_q == S_IDLE) & ~rst_i & ifu_req_valid_i & ~lsu_win;
    lsu_req_ready_o = (state_q == S_IDLE) & ~rst_i & lsu_win;
    resp_fire       = (state_q == S_RESP) & mem_rsp_valid_i;
    ifu_rsp_valid_o = resp_fire & ~owner_lsu_q;
    lsu_rsp_valid_o = resp_fire & owner_lsu_q;
  end

  assign ifu_rdata_o     = mem_rdata_i;
  assign lsu_rdata_o     = mem_rdata_i;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = addr_q;
  assign mem_wen_o       = wen_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;

  // Transaction sequencer: latch winner, hand off downstream, await response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      owner_lsu_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
`ifdef MEM_ARB_RR_EN
      last_lsu_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_lsu_q     <= lsu_win;
            mem_req_valid_q <= 1'b1;
            state_q         <= S_REQ;
`ifdef MEM_ARB_RR_EN
            last_lsu_q      <= lsu_win;
`endif
            if (lsu_win) begin
              addr_q  <= lsu_addr_i;
              wen_q   <= lsu_wen_i;
              wdata_q <= lsu_wdata_i;
              wmask_q <= lsu_wmask_i;
            end else begin
              addr_q  <= ifu_addr_i;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              wmask_q <= '0;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_RESP;
          end
        end
        S_RESP: begin
          if (mem_rsp_valid_i) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          mem_req_valid_q <= 1'b0;
          state_q         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios plus randomized traffic for mem_arb,
// checked every cycle against a transaction-level reference model.
module tb_mem_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_v, ifu_rdy, ifu_rsp;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_v, lsu_rdy, lsu_wen, lsu_rsp;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_v, mem_rdy, mem_wen, mem_rsp;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_valid_i(ifu_v), .ifu_req_ready_o(ifu_rdy), .ifu_addr_i(ifu_addr),
    .ifu_rsp_valid_o(ifu_rsp), .ifu_rdata_o(ifu_rdata),
    .lsu_req_valid_i(lsu_v), .lsu_req_ready_o(lsu_rdy), .lsu_addr_i(lsu_addr),
    .lsu_wen_i(lsu_wen), .lsu_wdata_i(lsu_wdata), .lsu_wmask_i(lsu_wmask),
    .lsu_rsp_valid_o(lsu_rsp), .lsu_rdata_o(lsu_rdata),
    .mem_req_valid_o(mem_v), .mem_req_ready_i(mem_rdy), .mem_addr_o(mem_addr),
    .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_rsp_valid_i(mem_rsp), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one in-flight transaction) ----------
  bit          m_busy, m_issued, m_owner_lsu, m_last_lsu, m_w;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;

  // LSU takes a tie unless (round-robin build) it was the last one granted.
  function automatic bit lsu_wins();
`ifdef MEM_ARB_RR_EN
    return lsu_v && (!ifu_v || !m_last_lsu);
`else
    return lsu_v;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_issued <= 0; m_owner_lsu <= 0; m_last_lsu <= 0;
    end else if (!m_busy) begin
      if (ifu_v || lsu_v) begin
        m_w = lsu_wins();
        m_busy <= 1; m_issued <= 0; m_owner_lsu <= m_w; m_last_lsu <= m_w;
        m_addr  <= m_w ? lsu_addr : ifu_addr;
        m_wen   <= m_w ? lsu_wen : 1'b0;
        m_wdata <= m_w ? lsu_wdata : '0;
        m_wmask <= m_w ? lsu_wmask : '0;
      end
    end else if (!m_issued) begin
      if (mem_rdy) m_issued <= 1;
    end else if (mem_rsp) begin
      m_busy <= 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit idle_ok, exp_mv, exp_rsp;
    idle_ok = !rst && !m_busy;
    exp_mv  = !rst && m_busy && !m_issued;
    exp_rsp = !rst && m_busy && m_issued && mem_rsp;
    chk("ifu_ready", ifu_rdy, idle_ok && ifu_v && !lsu_wins());
    chk("lsu_ready", lsu_rdy, idle_ok && lsu_wins());
    chk("mem_valid", mem_v, exp_mv);
    chk("ifu_rsp_valid", ifu_rsp, exp_rsp && !m_owner_lsu);
    chk("lsu_rsp_valid", lsu_rsp, exp_rsp && m_owner_lsu);
    if (exp_mv)
      chk("mem_fields", {mem_addr, mem_wen, mem_wdata[26:0], mem_wmask},
          {m_addr, m_wen, m_wdata[26:0], m_wmask});
    if (exp_mv) chk("mem_wdata", mem_wdata, m_wdata);
    if (ifu_rsp) chk("ifu_rdata", ifu_rdata, mem_rdata);
    if (lsu_rsp) chk("lsu_rdata", lsu_rdata, mem_rdata);
  end

  // Waits (bounded) for an accept, then completes it with zero-wait memory.
  task automatic run_txn(input bit drop, output bit got_lsu);
    int unsigned n = 0;
    bit seen = 0;
    got_lsu = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (ifu_rdy || lsu_rdy) begin
        seen = 1; got_lsu = lsu_rdy;
      end else begin
        @(posedge clk); #1; n++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL txn_accept_timeout: no ready after %0d cycles, expected one", n);
      return;
    end
    @(posedge clk); #1;
    if (drop) begin ifu_v = 0; lsu_v = 0; end
    mem_rdy = 1;
    @(negedge clk); chk("txn_mem_valid", mem_v, 1);
    @(posedge clk); #1; mem_rdy = 0; mem_rsp = 1;
    @(negedge clk); chk("txn_rsp", got_lsu ? lsu_rsp : ifu_rsp, 1);
    @(posedge clk); #1; mem_rsp = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    bit    g;
    string exp_order;
    bit    acc_i, acc_l, hs, awaiting;
    int unsigned dly;

    rst = 1; ifu_v = 0; lsu_v = 0; ifu_addr = '0; lsu_addr = '0; lsu_wen = 0;
    lsu_wdata = '0; lsu_wmask = '0; mem_rdy = 0; mem_rsp = 0; mem_rdata = 32'h00100093;
    @(negedge clk);
    chk("reset_fields", {mem_addr, mem_wen, mem_wmask, mem_v}, '0);
    chk("reset_wdata", mem_wdata, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // IFU fetch with zero-wait memory.
    ifu_v = 1; ifu_addr = 32'h8000_0000; mem_rdy = 1;
    @(negedge clk); chk("t1_ifu_ready", ifu_rdy, 1);
    @(posedge clk); #1; ifu_v = 0;
    @(negedge clk); chk("t1_mem_valid", mem_v, 1);
    chk("t1_addr", mem_addr, 32'h8000_0000); chk("t1_wen", mem_wen, 0);
    @(posedge clk); #1; mem_rsp = 1; mem_rdy = 0;
    @(negedge clk); chk("t1_ifu_rsp", ifu_rsp, 1);
    chk("t1_rdata", ifu_rdata, 32'h0010_0093); chk("t1_lsu_rsp", lsu_rsp, 0);
    @(posedge clk); #1; mem_rsp = 0;

    // LSU store stalled 5 cycles by the memory, IFU waiting meanwhile.
    lsu_v = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 4'hF; ifu_v = 1; ifu_addr = 32'h8000_0004;
    @(negedge clk); chk("t2_lsu_ready", lsu_rdy, 1); chk("t2_ifu_ready", ifu_rdy, 0);
    @(posedge clk); #1; lsu_v = 0; lsu_addr = '0; lsu_wdata = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_mem_valid", mem_v, 1); chk("t2_addr", mem_addr, 32'h8000_1000);
      chk("t2_wen", mem_wen, 1); chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t2_wmask", mem_wmask, 4'hF); chk("t2_ifu_ready", ifu_rdy, 0);
      chk("t2_lsu_rsp", lsu_rsp, 0);
      @(posedge clk); #1;
    end
    mem_rdy = 1;
    @(negedge clk); chk("t2_ifu_ready_hs", ifu_rdy, 0);
    @(posedge clk); #1; mem_rdy = 0; mem_rsp = 1;
    @(negedge clk); chk("t2_lsu_ack", lsu_rsp, 1); chk("t2_ifu_rsp", ifu_rsp, 0);
    @(posedge clk); #1; mem_rsp = 0;
    run_txn(1, g); chk("t2_then_ifu", g, 0);

    // Both requesters valid for six transactions.
`ifdef MEM_ARB_RR_EN
    exp_order = "LILILI";
`else
    exp_order = "LLLLLL";
`endif
    ifu_v = 1; lsu_v = 1; lsu_wen = 0; lsu_addr = 32'h8000_2000;
    for (int i = 0; i < 6; i++) begin
      run_txn(0, g);
      chk("t3_grant", g, exp_order[i] == "L");
    end
    ifu_v = 0; lsu_v = 0;

    // Reset while in REQ, then a late response.
    @(posedge clk); #1; ifu_v = 1; ifu_addr = 32'h8000_0008;
    @(negedge clk); chk("t4_accept", ifu_rdy, 1);
    @(posedge clk); #1; ifu_v = 0;
    @(negedge clk); chk("t4_in_req", mem_v, 1);
    #2 rst = 1;
    #1 chk("t4_async_drop", mem_v, 0);
    @(posedge clk); #1; rst = 0; mem_rsp = 1;
    @(negedge clk); chk("t4_late_rsp", {ifu_rsp, lsu_rsp, mem_v}, 3'b000);
    @(posedge clk); #1; mem_rsp = 0; ifu_v = 1; ifu_addr = 32'h8000_000C;
    run_txn(1, g); chk("t4_next_ifu", g, 0);

    // Spurious responses in IDLE and in REQ.
    mem_rsp = 1;
    @(negedge clk); chk("t5_idle_spur", {ifu_rsp, lsu_rsp, mem_v}, 3'b000);
    @(posedge clk); #1; mem_rsp = 0; ifu_v = 1; ifu_addr = 32'h8000_0010;
    @(negedge clk); chk("t5_accept", ifu_rdy, 1);
    @(posedge clk); #1; ifu_v = 0; mem_rsp = 1;
    @(negedge clk); chk("t5_req_spur", {ifu_rsp, lsu_rsp, mem_v}, 3'b001);
    @(posedge clk); #1; mem_rsp = 0;
    @(negedge clk); chk("t5_still_req", mem_v, 1);
    chk("t5_addr", mem_addr, 32'h8000_0010);
    @(posedge clk); #1; mem_rdy = 1;
    @(posedge clk); #1; mem_rdy = 0; mem_rsp = 1;
    @(negedge clk); chk("t5_rsp", ifu_rsp, 1);
    @(posedge clk); #1; mem_rsp = 0;

    // Randomized traffic.
    awaiting = 0; dly = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc_i = ifu_rdy && ifu_v; acc_l = lsu_rdy && lsu_v; hs = mem_v && mem_rdy;
      @(posedge clk); #1;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1; ifu_v = 0; lsu_v = 0; mem_rsp = 0; awaiting = 0;
        @(posedge clk); #1; rst = 0;
        continue;
      end
      if (acc_i) ifu_v = 0;
      if (acc_l) lsu_v = 0;
      if (!ifu_v && $urandom_range(0, 2) == 0) begin
        ifu_v = 1; ifu_addr = $urandom;
      end
      if (!lsu_v && $urandom_range(0, 2) == 0) begin
        lsu_v = 1; lsu_addr = $urandom; lsu_wen = $urandom_range(0, 1);
        lsu_wdata = $urandom; lsu_wmask = MW'($urandom);
      end
      if (hs) begin awaiting = 1; dly = $urandom_range(0, 3); end
      mem_rsp = 0;
      if (awaiting) begin
        if (dly == 0) begin mem_rsp = 1; awaiting = 0; end
        else dly--;
      end
      mem_rdata = $urandom;
      mem_rdy = $urandom_range(0, 1);
      if (!awaiting && !mem_rsp && !mem_rdy && $urandom_range(0, 7) == 0) mem_rsp = 1;
    end

    @(posedge clk); #1; ifu_v = 0; lsu_v = 0; mem_rsp = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port-to-one memory arbiter and transaction sequencer for the multi-cycle NPC core. It shares the single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU), so instruction fetch and data access no longer need separate combinational memories. It sits between ifu/lsu and the memory (DPI or bus bridge), and allows one outstanding transaction at a time.

## Interface
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; write mask is DATA_WIDTH/8 bits

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- ifu_req_valid_i  in  1  IFU read request
- ifu_req_ready_o  out  1  IFU request accepted this cycle
- ifu_addr_i  in  ADDR_WIDTH  fetch address
- ifu_rsp_valid_o  out  1  fetch data valid
- ifu_rdata_o  out  DATA_WIDTH  fetch data
- lsu_req_valid_i  in  1  LSU request
- lsu_req_ready_o  out  1  LSU request accepted this cycle
- lsu_addr_i  in  ADDR_WIDTH  data address
- lsu_wen_i  in  1  1 means write, 0 means read
- lsu_wdata_i  in  DATA_WIDTH  store data
- lsu_wmask_i  in  DATA_WIDTH/8  byte strobes
- lsu_rsp_valid_o  out  1  load data valid or store acknowledge
- lsu_rdata_o  out  DATA_WIDTH  load data
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream accepts request
- mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o  out  widths as above  latched request fields
- mem_rsp_valid_i  in  1  downstream response, one cycle per transaction
- mem_rdata_i  in  DATA_WIDTH  downstream read data

## Operation
- FSM states: IDLE, REQ, RESP. Reset state is IDLE.
- IDLE:
  - Pick a winner among the valid requesters.
  - Assert the winner's req_ready_o combinationally.
  - On that edge, latch the winner's addr, wen, wdata and wmask, latch the owner (IFU or LSU), and go to REQ.
  - IFU transactions latch wen=0, wdata=0, wmask=0.
  - No valid requester: stay in IDLE and keep both readies at 0.
- REQ:
  - mem_req_valid_o=1 and the latched fields are held stable.
  - When mem_req_ready_i=1, go to RESP.
- RESP:
  - Wait for mem_rsp_valid_i.
  - In that cycle, the owner's rsp_valid_o = 1 (combinational pass-through) and go to IDLE.
- The owner's rdata_o always equals mem_rdata_i. Consumers sample it only while rsp_valid_o=1.
- Writes also complete through RESP; lsu_rsp_valid_o is the store acknowledge.
- Default arbitration is fixed priority: the LSU wins when both requesters are valid.
- mem_rsp_valid_i outside RESP is ignored.
- Both readies are 0 outside IDLE; requesters hold their requests until accepted.

## Timing
- Reset values: state IDLE, mem_req_valid_o 0, both req_ready_o 0, both rsp_valid_o 0, latched fields 0.
- Reset is asynchronous. Asserting it mid-transaction drops mem_req_valid_o immediately and abandons the transaction. A late mem_rsp_valid_i after reset is ignored because the FSM is in IDLE.
- Minimum latency with zero-wait memory:
  - accept at cycle N
  - mem_req_valid_o at N+1, with mem_req_ready_i=1
  - response at N+2
  - next accept possible at N+3
- Throughput is at most one transaction per 3 cycles.
- A response in the same cycle as the request handshake is a protocol violation; the earliest legal response is the cycle after the handshake.
- mem_req_ready_i may stay low indefinitely; the request fields do not change while waiting.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration using a 1-bit last-grant register. Reset value is IFU, so the first tie goes to the LSU.
  - On a tie, the requester not granted last wins. last-grant updates on every accept.
- MEM_ARB_RR_EN undefined: fixed LSU priority; no last-grant register.

## Test plan
- IFU only, addr 0x80000000, memory ready=1, response 0x00100093 one cycle after accept → ifu_req_ready_o at cycle 0, mem_req_valid_o at cycle 1 with mem_addr_o=0x80000000 and mem_wen_o=0, ifu_rsp_valid_o at cycle 2 with rdata 0x00100093, lsu_rsp_valid_o stays 0.
- LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, with mem_req_ready_i held low 5 cycles → fields stable all 5 cycles, lsu_rsp_valid_o only on the response, ifu_req_ready_o held 0 throughout.
- Both requesters valid continuously, 6 transactions:
  - without MEM_ARB_RR_EN → all 6 grants go to LSU
  - with MEM_ARB_RR_EN → grant order L,I,L,I,L,I
- rst_i asserted while in REQ, then mem_rsp_valid_i pulsed after release → mem_req_valid_o falls immediately, no rsp_valid_o generated, next IFU request accepted normally.
- Spurious mem_rsp_valid_i while in IDLE and REQ → ignored; both rsp_valid_o stay 0 and the state is unchanged.
